// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared opcode/rt encodings, FSM state type and branch-decode helpers for the
// decode-stage branch resolution controller.
package branch_pkg;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SLOT = 2'd2
    } br_state_t;

    function automatic logic is_branch_f(input logic [5:0] op, input logic [4:0] rt);
        logic hit;
        hit = 1'b0;
        case (op)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: hit = 1'b1;
            OP_REGIMM: hit = (rt == RT_BLTZ) || (rt == RT_BGEZ) ||
                             (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Only BEQ/BNE compare two registers; the rest test rs against zero.
    function automatic logic need_rt_f(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic is_link_f(input logic [5:0] op, input logic [4:0] rt);
        return (op == OP_REGIMM) && ((rt == RT_BLTZAL) || (rt == RT_BGEZAL));
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_stats.sv
// Bank of saturating event counters; used by branch_resolve_ctrl only when
// BRANCH_STATS_EN is defined.
module branch_stats_counters #(
    parameter int W = 16,
    parameter int N = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        i_inc,
    output logic [N-1:0][W-1:0] o_cnt
);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cnt
            logic [W-1:0] r_cnt;

            // Counters stick at all-ones rather than wrapping.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (i_inc[gi] && (r_cnt != {W{1'b1}})) begin
                    r_cnt <= r_cnt + W'(1);
                end
            end

            assign o_cnt[gi] = r_cnt;
        end
    endgenerate

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Decode-stage branch controller: stalls until operands are final, samples the
// shared comparator, writes the $31 link and redirects the PC after the delay
// slot. Optional statistics counters are enabled with BRANCH_STATS_EN.
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int STATS_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [5:0]        id_op,
    input  logic [4:0]        id_rt,
    input  logic [15:0]       id_imm,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              rs_ready,
    input  logic              rt_ready,
    input  logic              stall_ext,
    output logic [5:0]        cmp_op,
    output logic [4:0]        cmp_rt,
    output logic [DATA_W-1:0] cmp_a,
    output logic [DATA_W-1:0] cmp_b,
    input  logic              cmp_c,
    output logic              id_stall,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              link_we,
    output logic [DATA_W-1:0] link_data
`ifdef BRANCH_STATS_EN
    ,
    output logic [STATS_W-1:0] stat_branches,
    output logic [STATS_W-1:0] stat_taken,
    output logic [STATS_W-1:0] stat_stall_cycles
`endif
);

    br_state_t         r_state;
    logic              r_taken;
    logic [DATA_W-1:0] r_target;
    logic              r_redirect_valid;
    logic [DATA_W-1:0] r_redirect_pc;
    logic              r_link_we;
    logic [DATA_W-1:0] r_link_data;

    logic              w_is_branch;
    logic              w_ready;
    logic              w_resolve;
    logic              w_slot_accept;
    logic              w_stall;
    logic [DATA_W-1:0] w_offset;
    logic [DATA_W-1:0] w_target;

    assign w_is_branch = is_branch_f(id_op, id_rt);
    assign w_ready     = rs_ready && (rt_ready || !need_rt_f(id_op));
    assign w_offset    = {{(DATA_W-16){id_imm[15]}}, id_imm} << 2;
    assign w_target    = id_pc + DATA_W'(4) + w_offset;

    // In WAIT the ID register is frozen, so the branch is not re-decoded.
    always_comb begin
        w_resolve     = 1'b0;
        w_slot_accept = 1'b0;
        w_stall       = 1'b0;
        case (r_state)
            IDLE: begin
                w_resolve = id_valid && w_is_branch && w_ready && !stall_ext;
                w_stall   = id_valid && w_is_branch && !w_ready;
            end
            WAIT: begin
                w_resolve = w_ready && !stall_ext;
                w_stall   = !w_ready;
            end
            SLOT: begin
                w_slot_accept = id_valid && !stall_ext;
            end
            default: begin
                w_resolve     = 1'b0;
                w_slot_accept = 1'b0;
                w_stall       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_taken          <= 1'b0;
            r_target         <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_link_we        <= 1'b0;
            r_link_data      <= '0;
        end else begin
            r_redirect_valid <= 1'b0;
            r_link_we        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_resolve) begin
                        r_state <= SLOT;
                    end else if (id_valid && w_is_branch) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_resolve) begin
                        r_state <= SLOT;
                    end
                end
                SLOT: begin
                    // The delay-slot instruction is never decoded as a branch.
                    if (w_slot_accept) begin
                        r_redirect_valid <= r_taken;
                        r_redirect_pc    <= r_target;
                        r_state          <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_resolve) begin
                r_taken  <= cmp_c;
                r_target <= w_target;
                if (is_link_f(id_op, id_rt)) begin
                    r_link_we   <= 1'b1;
                    r_link_data <= id_pc + DATA_W'(8);
                end
            end
        end
    end

    assign cmp_op         = id_valid ? id_op  : '0;
    assign cmp_rt         = id_valid ? id_rt  : '0;
    assign cmp_a          = id_valid ? rs_val : '0;
    assign cmp_b          = id_valid ? rt_val : '0;
    assign id_stall       = w_stall;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign link_we        = r_link_we;
    assign link_data      = r_link_data;

`ifdef BRANCH_STATS_EN
    logic [2:0]              w_stat_inc;
    logic [2:0][STATS_W-1:0] w_stat_cnt;

    assign w_stat_inc = {w_stall, w_resolve && cmp_c, w_resolve};

    branch_stats_counters #(
        .W (STATS_W),
        .N (3)
    ) u_stats (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_stat_inc),
        .o_cnt (w_stat_cnt)
    );

    assign stat_branches     = w_stat_cnt[0];
    assign stat_taken        = w_stat_cnt[1];
    assign stat_stall_cycles = w_stat_cnt[2];
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: stimulus pushes expected redirect
// and link events (value + cycle); a negedge monitor pops and compares them.
module tb_branch_resolve_ctrl;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [5:0]        id_op;
    logic [4:0]        id_rt;
    logic [15:0]       id_imm;
    logic [DATA_W-1:0] id_pc;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              rs_ready;
    logic              rt_ready;
    logic              stall_ext;
    logic [5:0]        cmp_op;
    logic [4:0]        cmp_rt;
    logic [DATA_W-1:0] cmp_a;
    logic [DATA_W-1:0] cmp_b;
    logic              cmp_c;
    logic              id_stall;
    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_pc;
    logic              link_we;
    logic [DATA_W-1:0] link_data;
`ifdef BRANCH_STATS_EN
    logic [15:0] stat_branches;
    logic [15:0] stat_taken;
    logic [15:0] stat_stall_cycles;
`endif

    branch_resolve_ctrl #(.DATA_W(DATA_W), .STATS_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_op          (id_op),
        .id_rt          (id_rt),
        .id_imm         (id_imm),
        .id_pc          (id_pc),
        .rs_val         (rs_val),
        .rt_val         (rt_val),
        .rs_ready       (rs_ready),
        .rt_ready       (rt_ready),
        .stall_ext      (stall_ext),
        .cmp_op         (cmp_op),
        .cmp_rt         (cmp_rt),
        .cmp_a          (cmp_a),
        .cmp_b          (cmp_b),
        .cmp_c          (cmp_c),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .link_we        (link_we),
        .link_data      (link_data)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches     (stat_branches),
        .stat_taken        (stat_taken),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t redir_q[$];
    exp_t link_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("check %s: 0x%08h ok (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: compares every DUT redirect/link pulse against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            chk("quiet_in_reset", {30'd0, redirect_valid, link_we}, 32'd0);
        end else begin
            if (redirect_valid) begin
                if (redir_q.size() == 0) begin
                    chk("unexpected_redirect_pc", redirect_pc, 32'hDEAD_DEAD);
                end else begin
                    e = redir_q.pop_front();
                    chk("redirect_pc", redirect_pc, e.val);
                    chk("redirect_cycle", cyc, e.cyc);
                end
            end else if (redir_q.size() > 0 && redir_q[0].cyc <= cyc) begin
                e = redir_q.pop_front();
                chk("missing_redirect_pc", 32'hDEAD_DEAD, e.val);
            end
            if (link_we) begin
                if (link_q.size() == 0) begin
                    chk("unexpected_link_data", link_data, 32'hDEAD_DEAD);
                end else begin
                    e = link_q.pop_front();
                    chk("link_data", link_data, e.val);
                    chk("link_cycle", cyc, e.cyc);
                end
            end else if (link_q.size() > 0 && link_q[0].cyc <= cyc) begin
                e = link_q.pop_front();
                chk("missing_link_data", 32'hDEAD_DEAD, e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_valid  = 1'b0;
        id_op     = 6'd0;
        id_rt     = 5'd0;
        id_imm    = 16'd0;
        id_pc     = '0;
        rs_val    = '0;
        rt_val    = '0;
        rs_ready  = 1'b1;
        rt_ready  = 1'b1;
        stall_ext = 1'b0;
        cmp_c     = 1'b0;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [4:0] rt,
                             input logic [15:0] imm, input logic [31:0] pc);
        id_valid = 1'b1;
        id_op    = op;
        id_rt    = rt;
        id_imm   = imm;
        id_pc    = pc;
    endtask

    task automatic push_redir(input logic [31:0] pc, input int at);
        exp_t e;
        e.val = pc;
        e.cyc = at;
        redir_q.push_back(e);
    endtask

    task automatic push_link(input logic [31:0] d, input int at);
        exp_t e;
        e.val = d;
        e.cyc = at;
        link_q.push_back(e);
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_link_data", link_data, 32'd0);
        chk("rst_cmp_a_idle", cmp_a, 32'd0);
        reset = 1'b0;
        tick();

        // 1: BEQ taken, delay slot accepted at once
        set_instr(6'b000100, 5'd5, 16'h0004, 32'h0040_0000);
        rs_val = 32'd5; rt_val = 32'd5; cmp_c = 1'b1;
        #1;
        chk("t1_id_stall", {31'd0, id_stall}, 32'd0);
        chk("t1_cmp_a", cmp_a, 32'd5);
        chk("t1_cmp_op", {26'd0, cmp_op}, 32'h4);
        tick();
        set_instr(6'd0, 5'd0, 16'd0, 32'h0040_0004);
        push_redir(32'h0040_0014, cyc + 1);
        tick();
        set_idle();
        repeat (2) tick();

        // 2: BNE waits three cycles for rt, then resolves not-taken
        set_instr(6'b000101, 5'd3, 16'h0010, 32'h0000_0100);
        rs_ready = 1'b1; rt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_id_stall_wait", {31'd0, id_stall}, 32'd1);
            tick();
        end
        rt_ready = 1'b1; cmp_c = 1'b0;
        #1;
        chk("t2_id_stall_ready", {31'd0, id_stall}, 32'd0);
        tick();
        set_instr(6'd0, 5'd0, 16'd0, 32'h0000_0104);
        tick();
        set_idle();
        repeat (2) tick();

        // 3: BLTZAL taken with link; a branch in the delay slot is ignored
        set_instr(6'b000001, 5'b10000, 16'h0010, 32'h0000_1000);
        rs_val = 32'hFFFF_FFFF; cmp_c = 1'b1;
        push_link(32'h0000_1008, cyc + 1);
        tick();
        set_instr(6'b000100, 5'd2, 16'h0100, 32'h0000_1004);
        rs_ready = 1'b0; cmp_c = 1'b0;
        #1;
        chk("t3_slot_branch_no_stall", {31'd0, id_stall}, 32'd0);
        push_redir(32'h0000_1044, cyc + 1);
        tick();
        set_idle();
        repeat (3) tick();

        // 4: BGEZ blocked by stall_ext at decode, then delay slot held 2 cycles
        set_instr(6'b000001, 5'b00001, 16'hFFFF, 32'h0000_2000);
        stall_ext = 1'b1;
        #1;
        chk("t4_no_stall_on_ext", {31'd0, id_stall}, 32'd0);
        tick();
        stall_ext = 1'b0; cmp_c = 1'b1;
        tick();
        set_instr(6'd0, 5'd0, 16'd0, 32'h0000_2004);
        stall_ext = 1'b1; cmp_c = 1'b0;
        repeat (2) tick();
        stall_ext = 1'b0;
        push_redir(32'h0000_2000, cyc + 1);
        tick();
        set_idle();
        repeat (3) tick();

        // 5a: negative offset wraps below zero
        set_instr(6'b000100, 5'd1, 16'h8000, 32'h0000_0010);
        cmp_c = 1'b1;
        tick();
        set_instr(6'd0, 5'd0, 16'd0, 32'h0000_0014);
        cmp_c = 1'b0;
        push_redir(32'hFFFE_0014, cyc + 1);
        tick();
        set_idle();
        repeat (2) tick();

        // 5b: reset while in SLOT drops the pending redirect
        set_instr(6'b000100, 5'd1, 16'h8000, 32'h0000_0010);
        cmp_c = 1'b1;
        tick();
        set_instr(6'd0, 5'd0, 16'd0, 32'h0000_0014);
        cmp_c = 1'b0;
        reset = 1'b1;
        tick();
        chk("t5_rst_redirect_pc", redirect_pc, 32'd0);
        chk("t5_rst_link_data", link_data, 32'd0);
        reset = 1'b0;
        repeat (3) tick();
        set_idle();
        repeat (2) tick();

        // 6: REGIMM rt=00010 is not a branch
        set_instr(6'b000001, 5'b00010, 16'h0020, 32'h0000_3000);
        rs_ready = 1'b0; cmp_c = 1'b1;
        #1;
        chk("t6_no_stall", {31'd0, id_stall}, 32'd0);
        repeat (2) tick();
        set_instr(6'd0, 5'd0, 16'd0, 32'h0000_3004);
        rs_ready = 1'b1;
        repeat (2) tick();
        set_idle();
        repeat (4) tick();

        chk("redir_queue_drained", redir_q.size(), 32'd0);
        chk("link_queue_drained", link_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Decode-stage controller that sequences the shared branch comparator.
- Detects conditional branches (BEQ/BNE/BLEZ/BGTZ/REGIMM BLTZ/BGEZ/BLTZAL/BGEZAL).
- Stalls decode until both operands are forwarded-ready, then drives the comparator and samples its result.
- Computes the branch target and writes the $31 link for the AL variants.
- Issues a one-cycle PC redirect once the delay-slot instruction has been accepted in ID.

Parameters:
DATA_W, 32, operand/PC width
STATS_W, 16, width of statistics counters (optional feature only)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
id_valid  input  1  instruction in ID is valid
id_op  input  6  opcode field of ID instruction
id_rt  input  5  rt field of ID instruction
id_imm  input  16  immediate field
id_pc  input  DATA_W  PC of ID instruction
rs_val  input  DATA_W  forwarded rs operand
rt_val  input  DATA_W  forwarded rt operand
rs_ready  input  1  rs value final (no pending producer)
rt_ready  input  1  rt value final
stall_ext  input  1  downstream stall; freezes ID
cmp_op  output  6  to comparator op
cmp_rt  output  5  to comparator rt
cmp_a  output  DATA_W  to comparator a
cmp_b  output  DATA_W  to comparator b
cmp_c  input  1  comparator result (combinational)
id_stall  output  1  hold IF/ID (combinational)
redirect_valid  output  1  registered, one-cycle PC redirect
redirect_pc  output  DATA_W  registered branch target
link_we  output  1  registered, write $31
link_data  output  DATA_W  registered, id_pc+8

Behaviour:
- Branch decode:
  - is_branch = op in {000100, 000101, 000110, 000111}, or op=000001 with rt in {00000, 00001, 10000, 10001}.
  - Other REGIMM rt values are non-branch.
- Operand readiness:
  - need_rt = op in {000100, 000101}.
  - ready = rs_ready && (rt_ready || !need_rt).
- Comparator drive: cmp_op/cmp_rt/cmp_a/cmp_b = id_op/id_rt/rs_val/rt_val in every state (pass-through); 0 when !id_valid.
- FSM states IDLE, WAIT, SLOT.
  - IDLE:
    - id_valid && is_branch && ready && !stall_ext → resolve; go SLOT.
    - id_valid && is_branch && (!ready || stall_ext) → WAIT.
  - WAIT:
    - id_stall=1 while !ready.
    - ready && !stall_ext → resolve; go SLOT.
    - ID contents are held, so no re-decode.
  - Resolve cycle actions:
    - latch taken_q=cmp_c.
    - latch target_q = id_pc + 4 + (sext(id_imm)<<2), modulo 2^DATA_W (wraps silently).
    - if rt in {10000, 10001} && op=000001: link_we=1 and link_data=id_pc+8 next cycle (one pulse), regardless of taken.
  - SLOT:
    - waits for delay slot: id_valid && !stall_ext.
    - in that cycle, redirect_valid<=taken_q and redirect_pc<=target_q (visible next cycle for exactly one cycle); go IDLE.
    - a branch occupying the delay slot is treated as non-branch: no resolve, no redirect.
- id_stall = (state==IDLE && id_valid && is_branch && !ready) || (state==WAIT && !ready).
- Latency: ready branch → redirect_valid 2 cycles later, if the delay slot is accepted immediately.
- Reset (at any time, including mid-WAIT/SLOT): state=IDLE, taken_q=0, target_q=0, redirect_valid=0, redirect_pc=0, link_we=0, link_data=0; pending branch dropped.
- redirect_valid and link_we never assert in the cycle reset is high.

Optional Feature:
BRANCH_STATS_EN
- Defined:
  - adds outputs stat_branches, stat_taken, stat_stall_cycles (STATS_W each).
  - counters increment on resolve, resolve&&cmp_c, and id_stall cycles respectively.
  - counters saturate at all-ones and clear on reset.
- Undefined: ports and logic absent; no other behavioural change.

Decomposition:
- Shared package branch_pkg:
  - opcode constants OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ.
  - REGIMM rt constants RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL.
  - state enum br_state_t {IDLE, WAIT, SLOT}.
- One sub-module: branch_stats_counters (saturating counters), instantiated only under BRANCH_STATS_EN.

Test Plan:
1. BEQ at pc=0x00400000, imm=0x0004, rs=rt=5, both ready, cmp_c=1; delay slot next cycle → redirect_valid=1 with redirect_pc=0x00400014 two cycles after the branch; link_we=0.
2. BNE with rt_ready=0 for 3 cycles → id_stall=1 for 3 cycles, no redirect during them; cmp_c=0 at resolve → redirect_valid never asserts.
3. BLTZAL at pc=0x1000, rs=0xFFFFFFFF, cmp_c=1 → link_we pulse with link_data=0x1008; redirect_pc=0x1004+(imm<<2).
4. BGEZ taken, stall_ext=1 for 2 cycles while the delay slot is in ID → redirect held off; pulses exactly once after stall_ext falls.
5. imm=0x8000 at pc=0x00000010 → redirect_pc=0xFFFE0014 (negative offset, wrap); reset asserted while in SLOT → no redirect, all outputs 0 next cycle.
6. REGIMM with rt=00010 → not a branch: no stall, no redirect, no link.
